// File: rtl/cam_msg_ctrl_if.sv
// Framer-side write bus and descriptor handshake of the message-aware CAM write controller.
interface cam_msg_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  wr_cs_i;
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  start_message_i;
    logic                  end_message_i;
    logic                  cam_write_o;
    logic [ADDR_WIDTH-1:0] cam_index_o;
    logic [DATA_WIDTH-1:0] cam_data_o;
    logic                  desc_valid_o;
    logic [ADDR_WIDTH-1:0] desc_start_o;
    logic [ADDR_WIDTH-1:0] desc_end_o;
    logic                  desc_ready_i;
    logic                  full_o;
    logic                  drop_o;
    logic                  proto_err_o;

    modport master (
        output wr_cs_i, wr_en_i, data_i, start_message_i, end_message_i, desc_ready_i,
        input  cam_write_o, cam_index_o, cam_data_o, desc_valid_o, desc_start_o, desc_end_o,
        input  full_o, drop_o, proto_err_o
    );

    modport slave (
        input  wr_cs_i, wr_en_i, data_i, start_message_i, end_message_i, desc_ready_i,
        output cam_write_o, cam_index_o, cam_data_o, desc_valid_o, desc_start_o, desc_end_o,
        output full_o, drop_o, proto_err_o
    );
endinterface

// File: rtl/cam_msg_ctrl.sv
// Message-aware CAM write controller: circular write pointer, space reclaim, descriptor FIFO.
// Optional CAM_MSG_CTRL_STATS_EN adds saturating message/drop counters.
module cam_msg_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned MSG_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    cam_msg_ctrl_if.slave bus
`ifdef CAM_MSG_CTRL_STATS_EN
    ,
    output logic [15:0]   msg_count_o,
    output logic [15:0]   drop_count_o
`endif
);

    localparam int unsigned PW  = ADDR_WIDTH + 1;
    localparam int unsigned FAW = $clog2(MSG_DEPTH);
    localparam logic [PW-1:0]  CAM_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
    localparam logic [FAW:0]   FIFO_FULL = (FAW + 1)'(MSG_DEPTH);
    localparam logic [FAW:0]   FIFO_ONE  = (FAW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StInMsg, StDrop} state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         free_ptr_q, free_ptr_d;
    logic [PW-1:0]         msg_start_q, msg_start_d;

    logic                  cam_write_q;
    logic [ADDR_WIDTH-1:0] cam_index_q;
    logic [DATA_WIDTH-1:0] cam_data_q;
    logic                  full_q, drop_q, proto_err_q;

    // Start addresses need only the index; end keeps the wrap bit to rebuild free_ptr.
    logic [ADDR_WIDTH-1:0] fifo_start_q [MSG_DEPTH];
    logic [PW-1:0]         fifo_end_q   [MSG_DEPTH];
    logic [FAW:0]          fifo_wr_q, fifo_rd_q;
    logic [FAW:0]          fifo_count;
    logic [FAW-1:0]        head;
    logic                  fifo_full, desc_valid;

    logic                  beat, pop;
    logic                  accept, overflow, cam_we, push, drop, perr;
    logic [PW-1:0]         base, msg_base;
    logic [PW-1:0]         used_next;

    assign beat       = bus.wr_cs_i && bus.wr_en_i;
    assign fifo_count = fifo_wr_q - fifo_rd_q;
    assign fifo_full  = (fifo_count == FIFO_FULL);
    assign desc_valid = (fifo_count != '0);
    assign head       = fifo_rd_q[FAW-1:0];
    assign pop        = desc_valid && bus.desc_ready_i;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        msg_start_d = msg_start_q;
        base        = wr_ptr_q;
        msg_base    = msg_start_q;
        accept      = 1'b0;
        overflow    = 1'b0;
        cam_we      = 1'b0;
        push        = 1'b0;
        drop        = 1'b0;
        perr        = 1'b0;
        if (beat) begin
            case (state_q)
                StIdle: begin
                    if (bus.start_message_i) begin
                        accept   = 1'b1;
                        msg_base = wr_ptr_q;
                    end else begin
                        perr = 1'b1;
                    end
                end
                StInMsg: begin
                    accept = 1'b1;
                    // A fresh start inside a message abandons it and reuses its space.
                    if (bus.start_message_i) begin
                        base = msg_start_q;
                        perr = 1'b1;
                    end
                end
                StDrop: begin
                    if (bus.start_message_i) begin
                        accept   = 1'b1;
                        msg_base = wr_ptr_q;
                    end else if (bus.end_message_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (accept) begin
                overflow = ((base - free_ptr_q) == CAM_FULL) ||
                           (bus.end_message_i && fifo_full && !pop);
                if (overflow) begin
                    drop     = 1'b1;
                    wr_ptr_d = msg_base;
                    state_d  = bus.end_message_i ? StIdle : StDrop;
                end else begin
                    cam_we      = 1'b1;
                    wr_ptr_d    = base + PTR_ONE;
                    msg_start_d = msg_base;
                    push        = bus.end_message_i;
                    state_d     = bus.end_message_i ? StIdle : StInMsg;
                end
            end
        end
    end

    always_comb begin
        free_ptr_d = free_ptr_q;
        if (pop) begin
            free_ptr_d = fifo_end_q[head] + PTR_ONE;
        end
    end

    assign used_next = wr_ptr_d - free_ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            free_ptr_q  <= '0;
            msg_start_q <= '0;
            cam_write_q <= 1'b0;
            cam_index_q <= '0;
            cam_data_q  <= '0;
            full_q      <= 1'b0;
            drop_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            free_ptr_q  <= free_ptr_d;
            msg_start_q <= msg_start_d;
            cam_write_q <= cam_we;
            full_q      <= (used_next == CAM_FULL);
            drop_q      <= drop;
            proto_err_q <= perr;
            if (cam_we) begin
                cam_index_q <= base[ADDR_WIDTH-1:0];
                cam_data_q  <= bus.data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_q <= '0;
            fifo_rd_q <= '0;
            for (int i = 0; i < int'(MSG_DEPTH); i++) begin
                fifo_start_q[i] <= '0;
                fifo_end_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                fifo_start_q[fifo_wr_q[FAW-1:0]] <= msg_base[ADDR_WIDTH-1:0];
                fifo_end_q[fifo_wr_q[FAW-1:0]]   <= base;
                fifo_wr_q                        <= fifo_wr_q + FIFO_ONE;
            end
            if (pop) begin
                fifo_rd_q <= fifo_rd_q + FIFO_ONE;
            end
        end
    end

`ifdef CAM_MSG_CTRL_STATS_EN
    logic [15:0] msg_count_q, drop_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (push && (msg_count_q != 16'hFFFF)) begin
                msg_count_q <= msg_count_q + 16'd1;
            end
            if (drop && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign msg_count_o  = msg_count_q;
    assign drop_count_o = drop_count_q;
`endif

    assign bus.cam_write_o  = cam_write_q;
    assign bus.cam_index_o  = cam_index_q;
    assign bus.cam_data_o   = cam_data_q;
    assign bus.desc_valid_o = desc_valid;
    assign bus.desc_start_o = desc_valid ? fifo_start_q[head] : '0;
    assign bus.desc_end_o   = desc_valid ? fifo_end_q[head][ADDR_WIDTH-1:0] : '0;
    assign bus.full_o       = full_q;
    assign bus.drop_o       = drop_q;
    assign bus.proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_cam_msg_ctrl.sv
// Directed bench for cam_msg_ctrl: framing, abort, overflow, wrap and descriptor FIFO limits.
module tb_cam_msg_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    cam_msg_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

`ifdef CAM_MSG_CTRL_STATS_EN
    logic [15:0] msg_count;
    logic [15:0] drop_count;
`endif

    cam_msg_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .MSG_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef CAM_MSG_CTRL_STATS_EN
        ,
        .msg_count_o (msg_count),
        .drop_count_o(drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; returns #1 after the capturing edge.
    task automatic step(input logic cs, input logic s, input logic e,
                        input logic [31:0] d, input logic rdy);
        @(negedge clk);
        bus.wr_cs_i         = cs;
        bus.wr_en_i         = cs;
        bus.start_message_i = s;
        bus.end_message_i   = e;
        bus.data_i          = d;
        bus.desc_ready_i    = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.wr_cs_i = 1'b0; bus.wr_en_i = 1'b0; bus.start_message_i = 1'b0;
        bus.end_message_i = 1'b0; bus.data_i = '0; bus.desc_ready_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.wr_cs_i = 1'b0; bus.wr_en_i = 1'b0; bus.start_message_i = 1'b0;
        bus.end_message_i = 1'b0; bus.data_i = '0; bus.desc_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_cam_write", 64'(bus.cam_write_o), 64'd0);
        chk("rst_cam_index", 64'(bus.cam_index_o), 64'd0);
        chk("rst_cam_data", 64'(bus.cam_data_o), 64'd0);
        chk("rst_desc_valid", 64'(bus.desc_valid_o), 64'd0);
        chk("rst_desc_start", 64'(bus.desc_start_o), 64'd0);
        chk("rst_desc_end", 64'(bus.desc_end_o), 64'd0);
        chk("rst_full", 64'(bus.full_o), 64'd0);
        chk("rst_drop", 64'(bus.drop_o), 64'd0);
        chk("rst_proto", 64'(bus.proto_err_o), 64'd0);

        // 3-beat message from reset
        step(1'b1, 1'b1, 1'b0, 32'hA0, 1'b0);
        chk("a0_write", 64'(bus.cam_write_o), 64'd1);
        chk("a0_index", 64'(bus.cam_index_o), 64'd0);
        chk("a0_data", 64'(bus.cam_data_o), 64'hA0);
        chk("a0_valid", 64'(bus.desc_valid_o), 64'd0);
        step(1'b1, 1'b0, 1'b0, 32'hA1, 1'b0);
        chk("a1_index", 64'(bus.cam_index_o), 64'd1);
        step(1'b1, 1'b0, 1'b1, 32'hA2, 1'b0);
        chk("a2_index", 64'(bus.cam_index_o), 64'd2);
        chk("a2_data", 64'(bus.cam_data_o), 64'hA2);
        chk("a_desc_valid", 64'(bus.desc_valid_o), 64'd1);
        chk("a_desc_start", 64'(bus.desc_start_o), 64'd0);
        chk("a_desc_end", 64'(bus.desc_end_o), 64'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("a_pop_valid", 64'(bus.desc_valid_o), 64'd0);
        chk("a_pop_idle_write", 64'(bus.cam_write_o), 64'd0);
        chk("a_free_ptr", 64'(dut.free_ptr_q), 64'd3);

        // Single-beat message at index 3
        step(1'b1, 1'b1, 1'b1, 32'hB0, 1'b0);
        chk("b_index", 64'(bus.cam_index_o), 64'd3);
        chk("b_desc_start", 64'(bus.desc_start_o), 64'd3);
        chk("b_desc_end", 64'(bus.desc_end_o), 64'd3);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("b_free_ptr", 64'(dut.free_ptr_q), 64'd4);

        // Beat without start in IDLE
        step(1'b1, 1'b0, 1'b0, 32'hDEAD, 1'b0);
        chk("perr_no_write", 64'(bus.cam_write_o), 64'd0);
        chk("perr_pulse", 64'(bus.proto_err_o), 64'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("perr_clear", 64'(bus.proto_err_o), 64'd0);

        // Abort: start inside a message restarts at the old msg_start (4)
        step(1'b1, 1'b1, 1'b0, 32'hC0, 1'b0);
        chk("c0_index", 64'(bus.cam_index_o), 64'd4);
        step(1'b1, 1'b0, 1'b0, 32'hC1, 1'b0);
        chk("c1_index", 64'(bus.cam_index_o), 64'd5);
        step(1'b1, 1'b1, 1'b0, 32'hC2, 1'b0);
        chk("abort_write", 64'(bus.cam_write_o), 64'd1);
        chk("abort_index", 64'(bus.cam_index_o), 64'd4);
        chk("abort_perr", 64'(bus.proto_err_o), 64'd1);
        step(1'b1, 1'b0, 1'b1, 32'hC3, 1'b0);
        chk("c3_index", 64'(bus.cam_index_o), 64'd5);
        chk("c_desc_start", 64'(bus.desc_start_o), 64'd4);
        chk("c_desc_end", 64'(bus.desc_end_o), 64'd5);
        chk("c3_perr", 64'(bus.proto_err_o), 64'd0);

        // Reset mid-message discards it; then single beat from reset gives {0,0}
        step(1'b1, 1'b1, 1'b0, 32'hE0, 1'b0);
        do_reset();
        #1;
        chk("rst2_valid", 64'(bus.desc_valid_o), 64'd0);
        step(1'b1, 1'b1, 1'b1, 32'hE1, 1'b0);
        chk("e_desc_start", 64'(bus.desc_start_o), 64'd0);
        chk("e_desc_end", 64'(bus.desc_end_o), 64'd0);
        chk("e_valid", 64'(bus.desc_valid_o), 64'd1);

        // Fill all 32 entries, then overflow
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, (i == 0), 1'b0, 32'(i), 1'b0);
            if (i == 30) chk("fill31_full", 64'(bus.full_o), 64'd0);
            if (i == 31) chk("fill32_full", 64'(bus.full_o), 64'd1);
        end
        chk("fill_index", 64'(bus.cam_index_o), 64'd31);
        step(1'b1, 1'b0, 1'b0, 32'h33, 1'b0);
        chk("ovf_write", 64'(bus.cam_write_o), 64'd0);
        chk("ovf_drop", 64'(bus.drop_o), 64'd1);
        chk("ovf_full", 64'(bus.full_o), 64'd0);
        chk("ovf_wr_ptr", 64'(dut.wr_ptr_q), 64'd0);
        step(1'b1, 1'b0, 1'b1, 32'h34, 1'b0);
        chk("drop_end_write", 64'(bus.cam_write_o), 64'd0);
        chk("drop_end_drop", 64'(bus.drop_o), 64'd0);
        chk("drop_end_valid", 64'(bus.desc_valid_o), 64'd0);

        // Move free_ptr to 30, then a message that wraps
        for (int i = 0; i < 30; i++) begin
            step(1'b1, (i == 0), (i == 29), 32'(i), 1'b0);
        end
        chk("m30_desc_end", 64'(bus.desc_end_o), 64'd29);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("m30_free_ptr", 64'(dut.free_ptr_q), 64'd30);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), (i == 3), 32'h100 + 32'(i), 1'b0);
            chk("wrap_index", 64'(bus.cam_index_o), 64'((30 + i) % 32));
        end
        chk("wrap_desc_start", 64'(bus.desc_start_o), 64'd30);
        chk("wrap_desc_end", 64'(bus.desc_end_o), 64'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_free_ptr", 64'(dut.free_ptr_q), 64'd34);

        // Descriptor FIFO limit: four held, fifth drops, sixth with same-cycle pop accepted
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 32'h200 + 32'(i), 1'b0);
            chk("fifo_fill_index", 64'(bus.cam_index_o), 64'(2 + i));
        end
        chk("fifo_head_start", 64'(bus.desc_start_o), 64'd2);
        step(1'b1, 1'b1, 1'b1, 32'h204, 1'b0);
        chk("fifo_ovf_write", 64'(bus.cam_write_o), 64'd0);
        chk("fifo_ovf_drop", 64'(bus.drop_o), 64'd1);
        step(1'b1, 1'b1, 1'b1, 32'h205, 1'b1);
        chk("fifo_pp_write", 64'(bus.cam_write_o), 64'd1);
        chk("fifo_pp_index", 64'(bus.cam_index_o), 64'd6);
        chk("fifo_pp_drop", 64'(bus.drop_o), 64'd0);
        chk("fifo_pp_head", 64'(bus.desc_start_o), 64'd3);
        chk("fifo_pp_valid", 64'(bus.desc_valid_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
